mult_accum_stage: RTL

- Downstream consumer of the combinational multiplier `mult_comb`: takes its `prod` output one product per handshake and accumulates a block of `len` products into a wide sum.
- Presents the sum to the next stage with a valid/ready handshake.
- Forms the accumulate half of a multiply-accumulate datapath.
- Single clock domain, registered outputs.

---
 rtl/mult_accum_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/mult_accum_stage.sv
// mult_accum_stage
//   Accumulate half of a multiply-accumulate datapath. Takes one unsigned
//   product per input handshake from the combinational multiplier. Sums a
//   block of `len` products into an ACC_W-bit accumulator. Presents the
//   result downstream with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush; aborts any block in progress
//   in_valid   upstream product valid
//   in_ready   stage can take a product (IDLE/ACCUM)
//   prod       2*n-bit unsigned product
//   len        products per block, sampled on a block's first beat (0 -> 1)
//   out_valid  result valid (HOLD)
//   out_ready  downstream accepts result
//   acc_out    accumulated sum, modulo 2^ACC_W
//   out_count  products summed into acc_out
//   overflow   sticky per block: an add carried out of the accumulator
//
// state | meaning
// IDLE  | waiting for the first beat of a block
// ACCUM | block open, adding beats until len_r products are summed
// HOLD  | result presented, waiting for the downstream handshake
module mult_accum_stage #(
  parameter int n     = 16,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*n-1:0]   prod,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_ext;
  logic             beat;

  // The accumulator and beat counter are the output registers themselves.
  // They keep their values through IDLE until the next block starts.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign beat      = in_valid && in_ready;
  assign prod_ext  = ACC_W'(prod);
  // One extra bit so the carry out of the accumulator is visible.
  assign sum_ext   = {1'b0, acc_out} + {1'b0, prod_ext};
  assign len_eff   = (len == '0) ? CNT_W'(1) : len;
  assign cnt_nxt   = out_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_out   <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
      len_r     <= '0;
    end else if (clear) begin
      // Any beat offered in this cycle is dropped along with the partial block.
      state     <= IDLE;
      acc_out   <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc_out   <= prod_ext;
            out_count <= CNT_W'(1);
            overflow  <= 1'b0;
            len_r     <= len_eff;
            state     <= (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_out   <= sum_ext[ACC_W-1:0];
            out_count <= cnt_nxt;
            overflow  <= overflow | sum_ext[ACC_W];
            if (cnt_nxt == len_r) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
